// File: rtl/s2neuron_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s2neuron_pkg : Q12.20 constants, FSM encoding and saturation helper.
// Revision 1.0
// ---------------------------------------------------------------------------
package s2neuron_pkg;

  localparam int DATA_W = 32;
  localparam int INT_W  = 12;
  localparam int FRAC_W = 20;
  localparam int GUARD  = 4;
  localparam int WIDE_W = 64;

  localparam logic [DATA_W-1:0] Q_ONE = DATA_W'(1) << FRAC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              flag;
  } sat_t;

  // Fits in DATA_W only when every bit from the DATA_W sign bit upward agrees.
  function automatic sat_t saturate(input logic [WIDE_W-1:0] val);
    sat_t                   res;
    logic [WIDE_W-DATA_W:0] top;
    top      = val[WIDE_W-1:DATA_W-1];
    res.flag = !((&top) || !(|top));
    if (!res.flag) begin
      res.value = val[DATA_W-1:0];
    end else if (val[WIDE_W-1]) begin
      res.value = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res.value = {1'b0, {(DATA_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/s2neuron_accum_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s2neuron_accum_lane : one lane of guarded accumulation, saturation and ReLU.
// Revision 1.0
// ---------------------------------------------------------------------------
module s2neuron_accum_lane #(
  parameter int DATA_W = 32,
  parameter int GUARD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_add,
  input  logic              i_done,
  input  logic              i_relu,
  input  logic [DATA_W-1:0] i_y,
  output logic [DATA_W-1:0] o_y,
  output logic              o_sat
);
  import s2neuron_pkg::*;

  localparam int ACC_W = DATA_W + GUARD;

  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_y;
  logic              r_sat;
  logic [ACC_W-1:0]  w_ext;
  logic [WIDE_W-1:0] w_wide;
  sat_t              w_sat;
  logic [DATA_W-1:0] w_relu;

  assign w_ext  = {{GUARD{i_y[DATA_W-1]}}, i_y};
  assign w_wide = {{(WIDE_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_sat  = saturate(w_wide);
  assign w_relu = (i_relu && w_sat.value[DATA_W-1]) ? '0 : w_sat.value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_y   <= '0;
      r_sat <= 1'b0;
    end else begin
      if (i_load) begin
        r_acc <= w_ext;
        r_sat <= 1'b0;
      end else if (i_add) begin
        r_acc <= r_acc + w_ext;
      end
      if (i_done) begin
        r_y   <= w_relu;
        r_sat <= w_sat.flag;
      end
    end
  end

  assign o_y   = r_y;
  assign o_sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/s2neuron_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s2neuron_accum : lane-wise Q12.20 sequence accumulator with saturation,
//                  optional ReLU and a valid/ready result handshake.
// Revision 1.0
// ---------------------------------------------------------------------------
module s2neuron_accum #(
  parameter int N_OUT  = 8,
  parameter int DATA_W = 32,
  parameter int INT_W  = 12,
  parameter int FRAC_W = 20,
  parameter int DEPTH  = 16,
  parameter int GUARD  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [N_OUT*DATA_W-1:0] y_in,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] y_out,
  output logic [N_OUT-1:0]        sat_flag,
  output logic                    len_err,
  output logic                    busy
);
  import s2neuron_pkg::*;

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int LANE_W = INT_W + FRAC_W;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_len_err;
  logic             r_relu;

  logic w_beat;
  logic w_cnt_full;
  logic w_load;
  logic w_add;
  logic w_done;
  logic w_close;

  assign w_beat     = in_valid & r_in_ready;
  assign w_cnt_full = (r_cnt == CNT_W'(DEPTH - 1));
  assign w_close    = (w_load | w_add) & (w_next == DONE);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_add  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_beat) begin
          w_load = 1'b1;
          w_next = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (w_beat) begin
          w_add = 1'b1;
          if (in_last || w_cnt_full) begin
            w_next = DONE;
          end
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // in_ready is registered from the next state so it stays low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
      r_len_err  <= 1'b0;
      r_relu     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == IDLE) || (w_next == ACCUM);
      if (w_load) begin
        r_cnt     <= CNT_W'(1);
        r_len_err <= 1'b0;
      end else if (w_add) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_cnt_full && !in_last) begin
          r_len_err <= 1'b1;
        end
      end else if ((r_state == HOLD) && out_ready) begin
        r_cnt <= '0;
      end
      if (w_close) begin
        r_relu <= relu_en;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
      s2neuron_accum_lane #(
        .DATA_W (LANE_W),
        .GUARD  (GUARD)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_add  (w_add),
        .i_done (w_done),
        .i_relu (r_relu),
        .i_y    (y_in[gi*DATA_W +: DATA_W]),
        .o_y    (y_out[gi*DATA_W +: DATA_W]),
        .o_sat  (sat_flag[gi])
      );
    end
  endgenerate

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign len_err   = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_s2neuron_accum.sv
`default_nettype none
// tb_s2neuron_accum : directed and randomized sequences checked against a
// lane-wise sum / clamp / ReLU reference model.
module tb_s2neuron_accum;
  localparam int N_OUT = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int W     = N_OUT * DW;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [W-1:0]     y_in;
  logic             relu_en;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     y_out;
  logic [N_OUT-1:0] sat_flag;
  logic             len_err;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q_data[$];
  bit           q_relu[$];

  always #5 clk = ~clk;

  s2neuron_accum #(
    .N_OUT(N_OUT), .DATA_W(DW), .INT_W(12), .FRAC_W(20), .DEPTH(DEPTH), .GUARD(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .y_in(y_in), .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .sat_flag(sat_flag), .len_err(len_err), .busy(busy)
  );

  // Reference: plain 64-bit sums over the beats that make up the sequence.
  function automatic void model(input bit use_last, output logic [W-1:0] ey,
                                output logic [N_OUT-1:0] es, output logic el);
    int           nb;
    longint       s;
    logic [DW-1:0] lane_v;
    logic [W-1:0] beat;
    nb = (q_data.size() > DEPTH) ? DEPTH : q_data.size();
    el = !(use_last && q_data.size() <= DEPTH);
    ey = '0;
    es = '0;
    for (int l = 0; l < N_OUT; l++) begin
      s = 0;
      for (int b = 0; b < nb; b++) begin
        beat   = q_data[b];
        lane_v = beat[l*DW +: DW];
        s      = s + longint'($signed(lane_v));
      end
      if (s > 64'sd2147483647) begin
        lane_v = 32'h7FFF_FFFF;
        es[l]  = 1'b1;
      end else if (s < -64'sd2147483648) begin
        lane_v = 32'h8000_0000;
        es[l]  = 1'b1;
      end else begin
        lane_v = s[DW-1:0];
      end
      if (q_relu[nb-1] && lane_v[DW-1]) lane_v = '0;
      ey[l*DW +: DW] = lane_v;
    end
  endfunction

  function automatic logic [W-1:0] rand_vec(input int mode);
    logic [W-1:0]  v;
    logic [DW-1:0] r;
    v = '0;
    for (int l = 0; l < N_OUT; l++) begin
      r = $urandom;
      case (mode)
        0:       v[l*DW +: DW] = r;
        1:       v[l*DW +: DW] = {{10{r[21]}}, r[21:0]};
        2:       v[l*DW +: DW] = (r & 32'h3FFF_FFFF) | 32'h4000_0000;
        default: v[l*DW +: DW] = (r & 32'h3FFF_FFFF) | 32'h8000_0000;
      endcase
    end
    return v;
  endfunction

  // Drives the queued beats, then captures the DONE/HOLD view of the outputs.
  task automatic drive_seq(input bit use_last, input int stall,
                           output logic ov_done, output logic ir_done, output logic ov_hold,
                           output logic [W-1:0] oy, output logic [N_OUT-1:0] os,
                           output logic ol, output bit stable);
    int g;
    out_ready = (stall == 0);
    for (int b = 0; b < q_data.size(); b++) begin
      in_valid = 1'b1;
      y_in     = q_data[b];
      in_last  = use_last && (b == q_data.size() - 1);
      relu_en  = q_relu[b];
      g = 0;
      while (!in_ready && g < 50) begin
        @(posedge clk); #1;
        g++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
        $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, want 1", in_ready, g);
        n_fail++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    relu_en  = ~relu_en;
    ov_done  = out_valid;
    ir_done  = in_ready;
    @(posedge clk); #1;
    ov_hold = out_valid;
    oy      = y_out;
    os      = sat_flag;
    ol      = len_err;
    stable  = 1'b1;
    if (stall > 0) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      y_in     = rand_vec(0);
      repeat (stall) begin
        @(posedge clk); #1;
        if (y_out !== oy || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; relu_en = 1'b0; out_ready = 1'b0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, len_err} !== 4'b0000) begin
      $display("FAIL reset_ctrl: {in_ready,out_valid,busy,len_err}=%b, want 0000",
               {in_ready, out_valid, busy, len_err});
      n_fail++;
    end
    n_checks++;
    if (y_out !== '0 || sat_flag !== '0) begin
      $display("FAIL reset_data: y_out=%h sat_flag=%b, want 0", y_out, sat_flag);
      n_fail++;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_release_ready: in_ready=%b before first edge, want 0", in_ready);
      n_fail++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_first_edge: in_ready=%b busy=%b, want 1 0", in_ready, busy);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    logic ov_d, ir_d, ov_h, ol; logic [W-1:0] oy; logic [N_OUT-1:0] os; bit st;
    q_data = {}; q_relu = {};
    q_data.push_back({N_OUT{32'h0010_0000}}); q_relu.push_back(1'b0);
    q_data.push_back({N_OUT{32'h0008_0000}}); q_relu.push_back(1'b0);
    drive_seq(1'b1, 0, ov_d, ir_d, ov_h, oy, os, ol, st);
    n_checks++;
    if ({ov_d, ir_d, ov_h} !== 3'b001) begin
      $display("FAIL basic_latency: done(out_valid,in_ready)=%b%b hold out_valid=%b, want 00 1",
               ov_d, ir_d, ov_h);
      n_fail++;
    end
    n_checks++;
    if (oy !== {N_OUT{32'h0018_0000}}) begin
      $display("FAIL basic_y: got %h want %h", oy, {N_OUT{32'h0018_0000}});
      n_fail++;
    end
    n_checks++;
    if (os !== '0 || ol !== 1'b0) begin
      $display("FAIL basic_flags: sat_flag=%b len_err=%b, want 0 0", os, ol);
      n_fail++;
    end
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL basic_return_idle: out_valid=%b busy=%b in_ready=%b, want 0 0 1",
               out_valid, busy, in_ready);
      n_fail++;
    end
  endtask

  task automatic test_single_relu();
    logic ov_d, ir_d, ov_h, ol; logic [W-1:0] oy; logic [N_OUT-1:0] os; bit st;
    q_data = {}; q_relu = {};
    q_data.push_back({{(N_OUT-1){32'h0010_0000}}, 32'hFFF0_0000}); q_relu.push_back(1'b1);
    drive_seq(1'b1, 0, ov_d, ir_d, ov_h, oy, os, ol, st);
    n_checks++;
    if (oy !== {{(N_OUT-1){32'h0010_0000}}, 32'h0000_0000} || ov_h !== 1'b1) begin
      $display("FAIL single_relu_y: got %h (valid %b) want %h (valid 1)", oy, ov_h,
               {{(N_OUT-1){32'h0010_0000}}, 32'h0000_0000});
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    logic ov_d, ir_d, ov_h, ol; logic [W-1:0] oy, v, exp_y; logic [N_OUT-1:0] os; bit st;
    v = '0; v[3*DW +: DW] = 32'h7000_0000;
    q_data = {}; q_relu = {};
    repeat (8) begin q_data.push_back(v); q_relu.push_back(1'b0); end
    drive_seq(1'b1, 0, ov_d, ir_d, ov_h, oy, os, ol, st);
    exp_y = '0; exp_y[3*DW +: DW] = 32'h7FFF_FFFF;
    n_checks++;
    if (oy !== exp_y || os !== 8'b0000_1000) begin
      $display("FAIL sat_pos: y=%h sat=%b want y=%h sat=00001000", oy, os, exp_y);
      n_fail++;
    end
    v = '0; v[3*DW +: DW] = 32'h9000_0000;
    q_data = {}; q_relu = {};
    repeat (7) begin q_data.push_back(v); q_relu.push_back(1'b1); end
    q_data.push_back(v); q_relu.push_back(1'b0);
    drive_seq(1'b1, 0, ov_d, ir_d, ov_h, oy, os, ol, st);
    exp_y = '0; exp_y[3*DW +: DW] = 32'h8000_0000;
    n_checks++;
    if (oy !== exp_y || os !== 8'b0000_1000) begin
      $display("FAIL sat_neg_relu_latch: y=%h sat=%b want y=%h sat=00001000", oy, os, exp_y);
      n_fail++;
    end
  endtask

  task automatic test_len_err();
    logic ov_d, ir_d, ov_h, ol, el; logic [W-1:0] oy, ey; logic [N_OUT-1:0] os, es; bit st;
    q_data = {}; q_relu = {};
    repeat (DEPTH) begin q_data.push_back(rand_vec(1)); q_relu.push_back(1'($urandom)); end
    model(1'b0, ey, es, el);
    drive_seq(1'b0, 0, ov_d, ir_d, ov_h, oy, os, ol, st);
    n_checks++;
    if (ol !== el || ov_d !== 1'b0 || ov_h !== 1'b1) begin
      $display("FAIL len_err_set: len_err=%b done_valid=%b hold_valid=%b, want %b 0 1",
               ol, ov_d, ov_h, el);
      n_fail++;
    end
    n_checks++;
    if (oy !== ey || os !== es) begin
      $display("FAIL len_err_y: y=%h sat=%b want y=%h sat=%b", oy, os, ey, es);
      n_fail++;
    end
    n_checks++;
    if (len_err !== 1'b1) begin
      $display("FAIL len_err_sticky: len_err in IDLE=%b, want 1", len_err);
      n_fail++;
    end
    q_data = {}; q_relu = {};
    repeat (2) begin q_data.push_back(rand_vec(1)); q_relu.push_back(1'b0); end
    model(1'b1, ey, es, el);
    drive_seq(1'b1, 0, ov_d, ir_d, ov_h, oy, os, ol, st);
    n_checks++;
    if (ol !== 1'b0 || oy !== ey) begin
      $display("FAIL len_err_clear: len_err=%b y=%h want 0 y=%h", ol, oy, ey);
      n_fail++;
    end
  endtask

  task automatic test_backpressure();
    logic ov_d, ir_d, ov_h, ol, el; logic [W-1:0] oy, ey; logic [N_OUT-1:0] os, es; bit st;
    q_data = {}; q_relu = {};
    repeat (3) begin q_data.push_back(rand_vec(0)); q_relu.push_back(1'($urandom)); end
    model(1'b1, ey, es, el);
    drive_seq(1'b1, 5, ov_d, ir_d, ov_h, oy, os, ol, st);
    n_checks++;
    if (st !== 1'b1 || ov_h !== 1'b1) begin
      $display("FAIL bp_hold_stable: stable=%b valid=%b, want 1 1", st, ov_h);
      n_fail++;
    end
    n_checks++;
    if (oy !== ey || os !== es) begin
      $display("FAIL bp_y: y=%h sat=%b want y=%h sat=%b", oy, os, ey, es);
      n_fail++;
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      n_fail++;
    end
    in_valid = 1'b1; in_last = 1'b1; relu_en = 1'b0; y_in = {N_OUT{32'h0010_0000}};
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL bp_pending_accept: busy=%b in_ready=%b, want 1 0", busy, in_ready);
      n_fail++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || y_out !== {N_OUT{32'h0010_0000}}) begin
      $display("FAIL bp_pending_result: valid=%b y=%h want 1 y=%h", out_valid, y_out,
               {N_OUT{32'h0010_0000}});
      n_fail++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ov_d, ir_d, ov_h, ol; logic [W-1:0] oy; logic [N_OUT-1:0] os; bit st; int g;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; in_last = 1'b0; y_in = rand_vec(1); relu_en = 1'b0;
      g = 0;
      while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL rst_mid_accum: busy=%b out_valid=%b, want 1 0", busy, out_valid);
      n_fail++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, len_err} !== 4'b0000 || y_out !== '0 || sat_flag !== '0) begin
      $display("FAIL rst_mid_outputs: ctrl=%b y=%h sat=%b, want 0000 0 0",
               {in_ready, out_valid, busy, len_err}, y_out, sat_flag);
      n_fail++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q_data = {}; q_relu = {};
    q_data.push_back({N_OUT{32'h0010_0000}}); q_relu.push_back(1'b0);
    drive_seq(1'b1, 0, ov_d, ir_d, ov_h, oy, os, ol, st);
    n_checks++;
    if (oy !== {N_OUT{32'h0010_0000}} || os !== '0 || ol !== 1'b0 || ov_h !== 1'b1) begin
      $display("FAIL rst_mid_fresh: y=%h sat=%b len_err=%b valid=%b want y=%h 0 0 1",
               oy, os, ol, ov_h, {N_OUT{32'h0010_0000}});
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic ov_d, ir_d, ov_h, ol, el; logic [W-1:0] oy, ey; logic [N_OUT-1:0] os, es; bit st;
    int len; bit ul; int mode;
    for (int it = 0; it < 10; it++) begin
      len  = $urandom_range(1, DEPTH);
      ul   = (len < DEPTH) ? 1'b1 : 1'($urandom);
      mode = $urandom_range(0, 3);
      q_data = {}; q_relu = {};
      repeat (len) begin q_data.push_back(rand_vec(mode)); q_relu.push_back(1'($urandom)); end
      model(ul, ey, es, el);
      drive_seq(ul, $urandom_range(0, 3), ov_d, ir_d, ov_h, oy, os, ol, st);
      n_checks++;
      if (oy !== ey || os !== es || ol !== el) begin
        $display("FAIL random_%0d: y=%h sat=%b len_err=%b want y=%h sat=%b len_err=%b",
                 it, oy, os, ol, ey, es, el);
        n_fail++;
      end
      n_checks++;
      if ({ov_d, ov_h, st} !== 3'b011) begin
        $display("FAIL random_hs_%0d: done_valid=%b hold_valid=%b stable=%b, want 0 1 1",
                 it, ov_d, ov_h, st);
        n_fail++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_single_relu();
    test_saturation();
    test_len_err();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
